ldpc_iter_ctrl: RTL and testbench
=================================

// Module: ldpc_iter_ctrl
// PURPOSE
// - Sequences iterative QC-LDPC decoding of one frame: accepts initial hard decisions, pulses the
//   decoder core once per iteration and feeds each result to the combinational syndrome checker.
// - Terminates on zero syndrome or after MAX_ITER iterations.
// - Sits between the frame source, the decoder core, the checker and the output sink.
// PARAMETERS
// - data_w   8   width of one circulant shift entry (checker mtx format)
// - C        8   circulant columns of the base matrix
// - R        4   circulant rows of the base matrix
// - D        8   circulant size; codeword width is R*D
// - MAX_ITER 16  iteration limit, >=1
// - ITER_W   5   iteration counter width; must satisfy 2**ITER_W > MAX_ITER
// PORTS
// - clk       in   1       clock; all state on rising edge
// - rst       in   1       asynchronous active-high reset
// - in_valid  in   1       frame available on in_hard
// - in_ready  out  1       controller idle, can accept a frame
// - in_hard   in   R*D     initial hard decisions
// - dec_start out  1       one-cycle pulse: decoder core runs one iteration on dec_word
// - dec_word  out  R*D     current word to decoder core (registered)
// - dec_done  in   1       one-cycle pulse: dec_bits valid
// - dec_bits  in   R*D     decoder iteration result
// - chk_dec   out  R*D     word to syndrome checker; same register as dec_word
// - chk_res   in   1       checker output: 1 = syndrome nonzero
// - out_valid out  1       result available
// - out_ready in   1       sink accepts result
// - out_bits  out  R*D     final word
// - out_iter  out  ITER_W  iterations performed
// - out_ok    out  1       1 = parity satisfied
// BEHAVIOUR
// - States: IDLE, CHECK, RUN, DONE; encoding free.
// - Reset: state=IDLE; word reg, iter, out_bits, out_iter, out_ok, out_valid, dec_start = 0.
// - in_ready = (state==IDLE), combinational; therefore 1 during and after reset.
// - IDLE: on in_valid&in_ready, word<=in_hard, iter<=0, go CHECK.
// - CHECK (1 cycle): chk_res sampled against word reg.
//   - chk_res==0: ok=1, go DONE.
//   - else iter==MAX_ITER: ok=0, go DONE.
//   - else: go RUN; dec_start=1 on the first RUN cycle only.
// - RUN: wait for dec_done, then word<=dec_bits, iter<=iter+1, go CHECK.
//   - dec_done in any other state is ignored.
//   - dec_done coincident with dec_start is ignored.
// - DONE: out_valid=1; out_bits/out_iter/out_ok hold stable until out_valid&out_ready,
//   then return to IDLE; out_valid drops the next cycle.
// - Latency: accept at edge N -> CHECK at N+1 -> out_valid at N+2 when the input is a codeword.
// - Iteration count saturates at MAX_ITER; no wrap. out_iter = iter at DONE entry.
// - Reset mid-frame: async return to IDLE; frame discarded; no out_valid.
// - A late dec_done after reset is ignored (state != RUN).
// CONFIGURATION
// - LDPC_CTRL_EARLY_STOP_EN defined: behaviour above (check before the first and after every iteration).
// - Undefined: no early stop.
//   - IDLE accept goes directly to RUN.
//   - After each dec_done: go RUN if iter+1<MAX_ITER, else CHECK.
//   - CHECK always goes to DONE with out_ok=~chk_res and out_iter=MAX_ITER.
// TESTING (defaults; bench models decoder with 3-cycle dec_done latency; real checker, identity shifts)
// - EARLY_STOP_EN, in_hard=0 -> out_valid 2 cycles after accept; out_iter=0, out_ok=1, no dec_start.
// - EARLY_STOP_EN, in_hard=32'h1, decoder returns 0
//   -> exactly one dec_start; out_iter=1, out_ok=1, out_bits=0.
// - EARLY_STOP_EN, decoder returns 32'h1 always -> 16 dec_start pulses; out_iter=16, out_ok=0.
// - out_ready held low 5 cycles in DONE -> out_valid and outputs stable, in_ready=0;
//   release -> IDLE, in_ready=1.
// - rst asserted mid-RUN, then dec_done arrives -> out_valid stays 0, in_ready=1, no state change.
// - Macro undefined, in_hard=0 -> 16 dec_start pulses; out_iter=16, out_ok=1.

Source files
------------

// File: rtl/ldpc_iter_ctrl_if.sv
// Handshake and data bundle around the LDPC iteration controller.
// master = controller side, slave = frame source / decoder core / checker / sink side.
interface ldpc_iter_ctrl_if #(
  parameter int unsigned W      = 32,
  parameter int unsigned ITER_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_hard;
  logic              dec_start;
  logic [W-1:0]      dec_word;
  logic              dec_done;
  logic [W-1:0]      dec_bits;
  logic [W-1:0]      chk_dec;
  logic              chk_res;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_bits;
  logic [ITER_W-1:0] out_iter;
  logic              out_ok;

  modport master (
    input  in_valid, in_hard, dec_done, dec_bits, chk_res, out_ready,
    output in_ready, dec_start, dec_word, chk_dec, out_valid, out_bits, out_iter, out_ok
  );

  modport slave (
    output in_valid, in_hard, dec_done, dec_bits, chk_res, out_ready,
    input  in_ready, dec_start, dec_word, chk_dec, out_valid, out_bits, out_iter, out_ok
  );
endinterface

// File: rtl/ldpc_iter_ctrl.sv
// Iteration sequencer for one QC-LDPC frame: decoder pulses, syndrome checks, result hand-off.
// Define LDPC_CTRL_EARLY_STOP_EN to check the syndrome before the first and after every iteration.
module ldpc_iter_ctrl #(
  parameter int unsigned data_w   = 8,
  parameter int unsigned C        = 8,
  parameter int unsigned R        = 4,
  parameter int unsigned D        = 8,
  parameter int unsigned MAX_ITER = 16,
  parameter int unsigned ITER_W   = 5
) (
  input logic               clk,
  input logic               rst,
  ldpc_iter_ctrl_if.master  bus
);

  localparam int unsigned W = R * D;
  localparam logic [ITER_W-1:0] MAX_ITER_C = ITER_W'(MAX_ITER);

  if (data_w == 0 || C < R || D == 0 || MAX_ITER < 1 || (2 ** ITER_W) <= MAX_ITER)
  begin : g_bad_cfg
    $error("ldpc_iter_ctrl: inconsistent parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_DONE} state_t;

  state_t            state_q;
  logic [W-1:0]      word_q;
  logic [ITER_W-1:0] iter_q;
  logic [ITER_W-1:0] iter_inc;
  logic [W-1:0]      out_bits_q;
  logic [ITER_W-1:0] out_iter_q;
  logic              out_ok_q;
  logic              out_valid_q;
  logic              dec_start_q;

  always_comb begin
    iter_inc = iter_q;
    if (iter_q != MAX_ITER_C) iter_inc = iter_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      word_q      <= '0;
      iter_q      <= '0;
      out_bits_q  <= '0;
      out_iter_q  <= '0;
      out_ok_q    <= 1'b0;
      out_valid_q <= 1'b0;
      dec_start_q <= 1'b0;
    end else begin
      dec_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            word_q <= bus.in_hard;
            iter_q <= '0;
`ifdef LDPC_CTRL_EARLY_STOP_EN
            state_q <= S_CHECK;
`else
            state_q     <= S_RUN;
            dec_start_q <= 1'b1;
`endif
          end
        end
        S_CHECK: begin
`ifdef LDPC_CTRL_EARLY_STOP_EN
          if (!bus.chk_res || iter_q == MAX_ITER_C) begin
            out_bits_q  <= word_q;
            out_iter_q  <= iter_q;
            out_ok_q    <= ~bus.chk_res;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            dec_start_q <= 1'b1;
            state_q     <= S_RUN;
          end
`else
          out_bits_q  <= word_q;
          out_iter_q  <= MAX_ITER_C;
          out_ok_q    <= ~bus.chk_res;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
`endif
        end
        S_RUN: begin
          // A dec_done landing in the same cycle as our own start pulse belongs to nothing we issued.
          if (bus.dec_done && !dec_start_q) begin
            word_q <= bus.dec_bits;
            iter_q <= iter_inc;
`ifdef LDPC_CTRL_EARLY_STOP_EN
            state_q <= S_CHECK;
`else
            if (iter_inc < MAX_ITER_C) begin
              dec_start_q <= 1'b1;
              state_q     <= S_RUN;
            end else begin
              state_q <= S_CHECK;
            end
`endif
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.dec_start = dec_start_q;
  assign bus.dec_word  = word_q;
  assign bus.chk_dec   = word_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bits  = out_bits_q;
  assign bus.out_iter  = out_iter_q;
  assign bus.out_ok    = out_ok_q;

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Directed bench for ldpc_iter_ctrl: 3-cycle decoder model and identity-shift syndrome checker.
// Scenario selection follows LDPC_CTRL_EARLY_STOP_EN like the design.
module tb_ldpc_iter_ctrl;
  localparam int unsigned W    = 32;
  localparam int unsigned IW   = 5;
  localparam int unsigned MAXI = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ldpc_iter_ctrl_if #(.W(W), .ITER_W(IW)) bus ();

  ldpc_iter_ctrl #(
    .data_w(8), .C(8), .R(4), .D(8), .MAX_ITER(MAXI), .ITER_W(IW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int cnt    = 0;
  logic [W-1:0] dec_ret = '0;

  // Identity shifts: syndrome bit d is the parity of bit d across the four circulant blocks.
  function automatic logic syn_nz(input logic [W-1:0] w);
    logic [7:0] s;
    s = '0;
    for (int b = 0; b < 4; b++) s ^= w[b*8 +: 8];
    return |s;
  endfunction

  assign bus.chk_res = syn_nz(bus.chk_dec);

  always @(negedge clk) begin
    bus.dec_done = 1'b0;
    if (cnt != 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        bus.dec_done = 1'b1;
        bus.dec_bits = dec_ret;
      end
    end
    if (bus.dec_start === 1'b1 && rst === 1'b0) begin
      cnt    = 3;
      pulses = pulses + 1;
    end
  end

  task automatic send(input logic [W-1:0] w, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      bus.in_valid = 1'b1;
      bus.in_hard  = w;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_out(input int maxc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (bus.out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_hard   = '0;
    bus.out_ready = 1'b1;
    bus.dec_bits  = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.dec_start !== 1'b0) begin errors++; $display("FAIL reset_dec_start: got %b want 0", bus.dec_start); end
    checks++; if (bus.dec_word !== '0) begin errors++; $display("FAIL reset_dec_word: got %h want 0", bus.dec_word); end
    checks++; if (bus.out_bits !== '0) begin errors++; $display("FAIL reset_out_bits: got %h want 0", bus.out_bits); end
    checks++; if (bus.out_iter !== '0) begin errors++; $display("FAIL reset_out_iter: got %0d want 0", bus.out_iter); end
    checks++; if (bus.out_ok !== 1'b0) begin errors++; $display("FAIL reset_out_ok: got %b want 0", bus.out_ok); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Runs one frame with out_ready high and compares the result against the given expectations.
  task automatic test_frame(input string nm, input logic [W-1:0] hard, input logic [W-1:0] ret,
                            input int exp_pulses, input int exp_iter, input logic exp_ok,
                            input logic [W-1:0] exp_bits);
    bit ok, seen;
    int p0;
    bus.out_ready = 1'b1;
    dec_ret = ret;
    p0 = pulses;
    send(hard, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_accept: in_ready never high", nm); end
    wait_out(300, seen);
    checks++; if (!seen) begin errors++; $display("FAIL %s_out_valid: timeout, want out_valid=1", nm); end
    checks++; if (pulses - p0 != exp_pulses) begin errors++; $display("FAIL %s_pulses: got %0d want %0d", nm, pulses - p0, exp_pulses); end
    checks++; if (bus.out_iter !== IW'(exp_iter)) begin errors++; $display("FAIL %s_iter: got %0d want %0d", nm, bus.out_iter, exp_iter); end
    checks++; if (bus.out_ok !== exp_ok) begin errors++; $display("FAIL %s_ok: got %b want %b", nm, bus.out_ok, exp_ok); end
    checks++; if (bus.out_bits !== exp_bits) begin errors++; $display("FAIL %s_bits: got %h want %h", nm, bus.out_bits, exp_bits); end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL %s_release: got valid=%b ready=%b want 0/1", nm, bus.out_valid, bus.in_ready); end
  endtask

`ifdef LDPC_CTRL_EARLY_STOP_EN
  task automatic test_latency;
    bit ok;
    int p0;
    bus.out_ready = 1'b1;
    p0 = pulses;
    send('0, ok);
    checks++; if (!ok || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL lat_check_cycle: got acc=%b valid=%b ready=%b want 1/0/0", ok, bus.out_valid, bus.in_ready); end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL lat_out_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.out_iter !== '0 || bus.out_ok !== 1'b1) begin errors++; $display("FAIL lat_result: got iter=%0d ok=%b want 0/1", bus.out_iter, bus.out_ok); end
    @(posedge clk); #1;
    checks++; if (pulses != p0) begin errors++; $display("FAIL lat_no_start: got %0d pulses want 0", pulses - p0); end
  endtask
`endif

  task automatic test_backpressure;
    bit ok, seen;
    logic [W-1:0] exp_bits;
    int exp_iter;
    exp_bits = 32'h00FF_00FF;
`ifdef LDPC_CTRL_EARLY_STOP_EN
    exp_iter = 1;
`else
    exp_iter = MAXI;
`endif
    bus.out_ready = 1'b0;
    dec_ret = exp_bits;
    send(32'h1234_5678, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_accept: in_ready never high"); end
    wait_out(300, seen);
    checks++; if (!seen) begin errors++; $display("FAIL bp_out_valid: timeout, want out_valid=1"); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_%0d: got valid=%b ready=%b want 1/0", i, bus.out_valid, bus.in_ready); end
      checks++; if (bus.out_bits !== exp_bits || bus.out_ok !== 1'b1 || bus.out_iter !== IW'(exp_iter)) begin
        errors++; $display("FAIL bp_stable_%0d: got bits=%h ok=%b iter=%0d want %h/1/%0d", i, bus.out_bits, bus.out_ok, bus.out_iter, exp_bits, exp_iter);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drop: got out_valid=%b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle: got in_ready=%b want 1", bus.in_ready); end
  endtask

  task automatic test_reset_mid_run;
    bit ok, started;
    int p0;
    bus.out_ready = 1'b1;
    dec_ret = 32'hA5A5_A5A4;
    p0 = pulses;
    send(32'h0000_0001, ok);
    started = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pulses > p0) begin
        started = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++; if (!ok || !started) begin errors++; $display("FAIL rmr_start: got acc=%b start=%b want 1/1", ok, started); end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.dec_start !== 1'b0) begin
      errors++; $display("FAIL rmr_async: got ready=%b valid=%b start=%b want 1/0/0", bus.in_ready, bus.out_valid, bus.dec_start);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rmr_late_%0d: got valid=%b ready=%b want 0/1", i, bus.out_valid, bus.in_ready); end
    end
    checks++; if (bus.dec_word !== '0) begin errors++; $display("FAIL rmr_word: got %h want 0", bus.dec_word); end
  endtask

  task automatic test_back_to_back;
`ifdef LDPC_CTRL_EARLY_STOP_EN
    test_frame("b2b_a", 32'h0000_0001, 32'h0000_0000, 1, 1, 1'b1, 32'h0000_0000);
    test_frame("b2b_b", 32'h0101_0101, 32'h0000_0100, 0, 0, 1'b1, 32'h0101_0101);
`else
    test_frame("b2b_a", 32'h0000_0001, 32'h0000_0000, MAXI, MAXI, 1'b1, 32'h0000_0000);
    test_frame("b2b_b", 32'h0101_0101, 32'h0000_0100, MAXI, MAXI, 1'b0, 32'h0000_0100);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
`ifdef LDPC_CTRL_EARLY_STOP_EN
    test_latency;
    test_frame("one_iter", 32'h0000_0001, 32'h0000_0000, 1, 1, 1'b1, 32'h0000_0000);
    test_frame("max_iter", 32'h0000_0001, 32'h0000_0001, MAXI, MAXI, 1'b0, 32'h0000_0001);
`else
    test_frame("full_ok", 32'h0000_0000, 32'h0000_0000, MAXI, MAXI, 1'b1, 32'h0000_0000);
    test_frame("full_bad", 32'h0000_0001, 32'h0000_0001, MAXI, MAXI, 1'b0, 32'h0000_0001);
`endif
    test_backpressure;
    test_reset_mid_run;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
